// File: rtl/gcd_accel_pkg.sv
// Shared definitions for the Wishbone GCD accelerator: register offsets,
// CTRL/STATUS bit positions, engine states and the STATUS packing helper.
package gcd_accel_pkg;

    localparam logic [1:0] REG_OPA  = 2'd0;
    localparam logic [1:0] REG_OPB  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_RES  = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_ERR_CLR = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_ERR     = 3;
    localparam int STAT_OCC_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } eng_state_t;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       empty,
        input logic       full,
        input logic       err,
        input logic [4:0] occ
    );
        logic [31:0] s;
        s = '0;
        s[STAT_BUSY]  = busy;
        s[STAT_EMPTY] = empty;
        s[STAT_FULL]  = full;
        s[STAT_ERR]   = err;
        s[STAT_OCC_LSB +: 5] = occ;
        return s;
    endfunction

endpackage

// File: rtl/gcd_engine.sv
// Iterative subtract/swap Euclid engine; holds its result in DONE until
// the consumer accepts it.
module gcd_engine
    import gcd_accel_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] res,
    output logic             res_val,
    input  logic             res_rdy,
    output logic             busy
);

    eng_state_t       state;
    eng_state_t       state_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a_n;
    logic [WIDTH-1:0] b_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a     <= '0;
            b     <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    a_n     = opa;
                    b_n     = opb;
                    state_n = ST_CALC;
                end
            end
            ST_CALC: begin
                if (a < b) begin
                    a_n = b;
                    b_n = a;
                end else if (b != '0) begin
                    a_n = a - b;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_rdy) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign res     = a;
    assign res_val = (state == ST_DONE);
    assign busy    = (state != ST_IDLE);

endmodule

// File: rtl/wb_gcd_accel.sv
// Wishbone-mapped GCD accelerator: operand regs, engine, result FIFO.
// Interrupt lines are generated only when GCD_ACCEL_IRQ_EN is defined.
module wb_gcd_accel
    import gcd_accel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o,
    output logic [2:0]  irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic             valid;
    logic             valid_q;
    logic             hit;
    logic             wr;
    logic             rd;
    logic [1:0]       reg_sel;
    logic [31:0]      rdata;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             err;
    logic             start_q;

    logic             ctrl_wr;
    logic             start_req;
    logic             start_ok;
    logic             start_bad;
    logic             flush;
    logic             err_clr;
    logic             pop_req;
    logic             pop;
    logic             pop_bad;
    logic             push;

    logic             eng_busy;
    logic [WIDTH-1:0] eng_res;
    logic             eng_val;
    logic             eng_rdy;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic [4:0]       occ;

    logic             unused;

    assign unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

    // A transfer is served once, on the cycle valid rises.
    assign valid   = wbs_stb_i & wbs_cyc_i;
    assign hit     = valid & ~valid_q;
    assign wr      = hit & wbs_we_i;
    assign rd      = hit & ~wbs_we_i;
    assign reg_sel = wbs_adr_i[3:2];

    assign ctrl_wr   = wr & (reg_sel == REG_CTRL) & wbs_sel_i[0];
    assign start_req = ctrl_wr & wbs_dat_i[CTRL_START];
    assign flush     = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
    assign err_clr   = ctrl_wr & wbs_dat_i[CTRL_ERR_CLR];
    assign start_ok  = start_req & ~eng_busy & ~start_q;
    assign start_bad = start_req & (eng_busy | start_q);

    assign pop_req = rd & (reg_sel == REG_RES);
    assign pop     = pop_req & ~empty;
    assign pop_bad = pop_req & empty;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign occ   = 5'(count);

    // A flush accepts and drops the engine result.
    assign eng_rdy = ~full | pop | flush;
    assign push    = eng_val & eng_rdy & ~flush;

    gcd_engine #(
        .WIDTH(WIDTH)
    ) u_engine (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .start  (start_q),
        .opa    (opa),
        .opb    (opb),
        .res    (eng_res),
        .res_val(eng_val),
        .res_rdy(eng_rdy),
        .busy   (eng_busy)
    );

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_OPA:  rdata[WIDTH-1:0] = opa;
            REG_OPB:  rdata[WIDTH-1:0] = opb;
            REG_CTRL: rdata = pack_status(eng_busy, empty, full, err, occ);
            REG_RES: begin
                if (!empty) begin
                    rdata[WIDTH-1:0] = mem[rd_ptr];
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            valid_q   <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            valid_q   <= valid;
            wbs_ack_o <= hit;
            if (rd) begin
                wbs_dat_o <= rdata;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            opa     <= '0;
            opb     <= '0;
            err     <= 1'b0;
            start_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (wr && reg_sel == REG_OPA && wbs_sel_i[i/8]) begin
                    opa[i] <= wbs_dat_i[i];
                end
                if (wr && reg_sel == REG_OPB && wbs_sel_i[i/8]) begin
                    opb[i] <= wbs_dat_i[i];
                end
            end
            if (start_bad || pop_bad) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            start_q <= start_ok;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= eng_res;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign busy_o = eng_busy;

`ifdef GCD_ACCEL_IRQ_EN
    assign irq = {1'b0, err, ~empty};
`else
    assign irq = 3'b000;
`endif

endmodule

// File: tb/tb_wb_gcd_accel.sv
// Directed and randomized bench for wb_gcd_accel against a queue-based
// model of the result FIFO and a plain Euclid reference.
module tb_wb_gcd_accel;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dati;
    logic        ack;
    logic [31:0] dato;
    logic        busy;
    logic [2:0]  irq;

    int checks = 0;
    int errors = 0;

    int unsigned q[$];
    bit          m_err;
    logic [31:0] m_opa;
    logic [31:0] m_opb;

    wb_gcd_accel #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dati),
        .wbs_ack_o(ack),
        .wbs_dat_o(dato),
        .busy_o   (busy),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned gcd_ref(input int unsigned x,
                                            input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [31:0] exp_status(input logic b);
        logic [31:0] s;
        s = '0;
        s[0] = b;
        s[1] = (q.size() == 0);
        s[2] = (q.size() == DEPTH);
        s[3] = m_err;
        s[12:8] = 5'(q.size());
        return s;
    endfunction

    function automatic logic [31:0] exp_irq();
        logic [31:0] v;
        v = '0;
`ifdef GCD_ACCEL_IRQ_EN
        v[0] = (q.size() != 0);
        v[1] = m_err;
`endif
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r & ((32'h1 << WIDTH) - 1);
    endfunction

    task automatic bus(input logic w, input logic [1:0] r,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rv);
        int n;
        logic got;
        @(negedge clk);
        stb = 1'b1;
        cyc = 1'b1;
        we = w;
        adr = {28'h0, r, 2'b00};
        dati = d;
        sel = s;
        n = 0;
        got = 1'b0;
        while (!got && n < 4) begin
            @(posedge clk);
            #1;
            n++;
            got = ack;
        end
        chk("ack_seen", {31'b0, got}, 32'd1);
        rv = dato;
        stb = 1'b0;
        cyc = 1'b0;
        we = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_len", {31'b0, ack}, 32'd0);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] dummy;
        bus(1'b1, r, d, s, dummy);
        if (r == 2'd0) m_opa = merge(m_opa, d, s);
        if (r == 2'd1) m_opb = merge(m_opb, d, s);
    endtask

    task automatic rdreg(input logic [1:0] r, output logic [31:0] v);
        bus(1'b0, r, 32'h0, 4'hF, v);
    endtask

    task automatic read_res(input string tag);
        logic [31:0] v;
        logic [31:0] e;
        rdreg(2'd3, v);
        if (q.size() == 0) begin
            e = 0;
            m_err = 1'b1;
        end else begin
            e = q.pop_front();
        end
        chk(tag, v, e);
    endtask

    task automatic check_status(input string tag, input logic b);
        logic [31:0] v;
        rdreg(2'd2, v);
        chk(tag, v, exp_status(b));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (busy && n < 70000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_gcd(input logic [31:0] a, input logic [31:0] b);
        wr(2'd0, a, 4'hF);
        wr(2'd1, b, 4'hF);
        wr(2'd2, 32'h1, 4'hF);
        wait_idle();
        q.push_back(gcd_ref(m_opa, m_opb));
    endtask

    initial begin
        logic [31:0] v;
        logic [3:0]  pat;
        int unsigned ra;
        int unsigned rb;

        rst = 1'b1;
        stb = 1'b0;
        cyc = 1'b0;
        we = 1'b0;
        sel = 4'h0;
        adr = '0;
        dati = '0;
        m_err = 1'b0;
        m_opa = '0;
        m_opb = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", dato, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_irq", {29'b0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_status("rst_status", 1'b0);

        // gcd(12,8): 6 CALC steps, result lands 8 cycles after the ack
        wr(2'd0, 32'd12, 4'hF);
        wr(2'd1, 32'd8, 4'hF);
        wr(2'd2, 32'h1, 4'hF);
        repeat (6) @(posedge clk);
        #1;
        chk("lat_busy7", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("lat_busy8", {31'b0, busy}, 32'd0);
        q.push_back(gcd_ref(12, 8));
        check_status("one_result", 1'b0);
        read_res("res_12_8");
        check_status("drained", 1'b0);

        // Fill the FIFO, fifth result waits in DONE
        wr(2'd0, 32'd9, 4'hF);
        wr(2'd1, 32'd6, 4'hF);
        for (int i = 0; i < 4; i++) begin
            wr(2'd2, 32'h1, 4'hF);
            wait_idle();
            q.push_back(gcd_ref(9, 6));
        end
        check_status("full4", 1'b0);
        chk("irq_full", {29'b0, irq}, exp_irq());
        wr(2'd2, 32'h1, 4'hF);
        repeat (20) @(posedge clk);
        #1;
        chk("hold_done_busy", {31'b0, busy}, 32'd1);
        check_status("full_busy", 1'b1);
        read_res("pop_full");
        q.push_back(gcd_ref(9, 6));
        wait_idle();
        check_status("refill4", 1'b0);
        wr(2'd2, 32'h2, 4'hF);
        q.delete();
        check_status("flushed", 1'b0);

        // Error paths
        wr(2'd0, 32'd200, 4'hF);
        wr(2'd1, 32'd1, 4'hF);
        wr(2'd2, 32'h1, 4'hF);
        wr(2'd2, 32'h1, 4'hF);
        m_err = 1'b1;
        chk("busy_err", {31'b0, busy}, 32'd1);
        check_status("start_busy_err", 1'b1);
        chk("irq_err", {29'b0, irq}, exp_irq());
        wait_idle();
        q.push_back(gcd_ref(200, 1));
        read_res("res_200_1");
        read_res("empty_read");
        check_status("empty_err", 1'b0);
        chk("irq_err2", {29'b0, irq}, exp_irq());
        wr(2'd2, 32'h8, 4'hF);
        m_err = 1'b0;
        check_status("err_cleared", 1'b0);
        chk("irq_clr", {29'b0, irq}, exp_irq());

        // Boundary operands
        run_gcd(32'd0, 32'd7);
        read_res("gcd_0_7");
        run_gcd(32'd7, 32'd0);
        read_res("gcd_7_0");
        run_gcd(32'd0, 32'd0);
        read_res("gcd_0_0");
        run_gcd(32'hFFFF, 32'h1);
        read_res("gcd_ffff_1");

        // Held strobe: exactly one ack
        @(negedge clk);
        stb = 1'b1;
        cyc = 1'b1;
        we = 1'b1;
        adr = 32'h0;
        dati = 32'h1234;
        sel = 4'hF;
        pat = 4'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            pat[i] = ack;
        end
        stb = 1'b0;
        cyc = 1'b0;
        we = 1'b0;
        m_opa = merge(m_opa, 32'h1234, 4'hF);
        @(posedge clk);
        #1;
        chk("hold_ack", {28'b0, pat}, 32'h1);
        wr(2'd0, 32'hABCDEF56, 4'b0001);
        rdreg(2'd0, v);
        chk("opa_byte0", v, m_opa);
        chk("opa_byte0_k", v, 32'h1256);
        wr(2'd1, 32'h00009900, 4'b0010);
        rdreg(2'd1, v);
        chk("opb_byte1", v, m_opb);

        // Randomized operands against the reference
        for (int i = 0; i < 24; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) ra = 0;
            if ($urandom_range(0, 7) == 0) rb = 0;
            run_gcd(ra, rb);
            if ($urandom_range(0, 1) == 1 || q.size() == DEPTH) begin
                while (q.size() != 0) read_res("rnd_res");
                if ($urandom_range(0, 3) == 0) begin
                    read_res("rnd_empty");
                    check_status("rnd_err", 1'b0);
                    wr(2'd2, 32'h8, 4'h1);
                    m_err = 1'b0;
                end
            end
            check_status("rnd_status", 1'b0);
        end
        while (q.size() != 0) read_res("rnd_drain");

        // Asynchronous reset mid-CALC
        wr(2'd0, 32'hFFFF, 4'hF);
        wr(2'd1, 32'h1, 4'hF);
        wr(2'd2, 32'h1, 4'hF);
        repeat (10) @(posedge clk);
        rdreg(2'd0, v);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        chk("pre_rst_dat", dato, 32'hFFFF);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ack", {31'b0, ack}, 32'd0);
        chk("arst_dat", dato, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_irq", {29'b0, irq}, 32'd0);
        q.delete();
        m_err = 1'b0;
        m_opa = '0;
        m_opb = '0;
        @(negedge clk);
        rst = 1'b0;
        check_status("arst_status", 1'b0);
        rdreg(2'd0, v);
        chk("arst_opa", v, m_opa);
        read_res("arst_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_gcd_accel.md
# wb_gcd_accel

Parametrised Wishbone-mapped GCD accelerator for the Caravel user area, replacing the direct bus-to-GcdUnit hookup. It adds memory-mapped operand registers, an iterative Euclid engine of configurable width, and a result FIFO so firmware can queue results. It also adds sticky error status, a registered single-cycle ack, and optional interrupts.

## Interface
- `WIDTH`, 16: operand/result width, 2..32.
- `DEPTH`, 4: result FIFO entries, power of two, 2..16.
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i` in 1: Wishbone strobe/cycle; `valid` = both high.
- `wbs_we_i` in 1: write enable.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_adr_i` in 32: only bits [3:2] decoded.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: registered ack.
- `wbs_dat_o` out 32: registered read data.
- `busy_o` out 1: engine not IDLE, for the logic analyzer.
- `irq` out 3: interrupt lines.

## Operation
- Register map by `adr[3:2]`:
  - 0 `OPA`, RW, bits [WIDTH-1:0].
  - 1 `OPB`, RW, bits [WIDTH-1:0].
  - 2 `CTRL/STATUS`.
  - 3 `RESULT`, RO.
  - Unused upper bits read 0.
- `OPA`/`OPB` writes honour `wbs_sel_i` per byte.
- CTRL write, acted on only if `sel[0]`:
  - bit0 `START`.
  - bit1 `FLUSH`, empties the FIFO.
  - bit3 write-1 clears `ERR`.
- STATUS read:
  - bit0 `busy`, bit1 `empty`, bit2 `full`, bit3 `ERR`.
  - bits[12:8] FIFO occupancy.
- RESULT read pops the FIFO head. Reading when empty returns 0, does not pop, and sets `ERR`.
- `START` while busy is ignored and sets `ERR`.
- Engine FSM:
  - IDLE: on START, load A=OPA, B=OPB, go to CALC.
  - CALC, one step per cycle:
    - if A<B, swap;
    - else if B≠0, A←A−B;
    - else go to DONE.
  - DONE: push A into the FIFO if not full, then go to IDLE. If full, hold DONE (busy=1) until space frees.
- gcd(x,0)=gcd(0,x)=x; gcd(0,0)=0.
- FLUSH coinciding with a DONE push: the flush wins and the result is discarded.
- Pop and push in the same cycle: occupancy is unchanged, and the popped data is the old head.
- Reset clears everything:
  - engine→IDLE; A, B, OPA, OPB = 0;
  - FIFO empty; ERR=0;
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `busy_o`=0, `irq`=0.
- Reset mid-computation discards the result.

## Timing
- Ack is asserted one cycle after `valid` first rises and lasts exactly one cycle.
- Ack is not reasserted while the same `stb` is held. A new transfer needs `valid` to drop for at least one cycle.
- All write side effects (register update, START, FLUSH, pop) take effect on the ack edge.
- Read data is valid with ack.
- Engine latency from START ack edge:
  - 1 cycle to enter CALC;
  - one cycle per CALC step;
  - 1 cycle in DONE;
  - the result is in the FIFO and busy=0 on the following cycle.
- Example, gcd(12,8): 6 CALC cycles, so busy=0 and empty=0 at cycle 8 after the START ack.
- Worst case is bounded by about 2·2^WIDTH steps. No timeout.

## Configuration
- `GCD_ACCEL_IRQ_EN` defined:
  - `irq[0]` = !empty (level);
  - `irq[1]` = ERR (level);
  - `irq[2]`=0.
- Not defined: `irq` tied to 3'b000 and no interrupt logic is instantiated. Register behaviour is identical either way.

## Structure
- Package `gcd_accel_pkg`:
  - register offsets;
  - CTRL/STATUS bit indices;
  - engine state enum (IDLE, CALC, DONE).
- Sub-module `gcd_engine`, parametrised by `WIDTH`:
  - ports `start`, `opa`, `opb`, `res`, `res_val`, `res_rdy`, `busy`;
  - contains the FSM and datapath.
- The FIFO and Wishbone decode stay in the top.

## Test plan
- Reset asserted asynchronously mid-CALC → all outputs 0 immediately; STATUS reads 0x2 after release.
- OPA=12, OPB=8, START → busy clears within 8 cycles of the START ack; RESULT reads 4; STATUS then reads empty=1.
- Queue 5 starts with DEPTH=4, each gcd(9,6) → FIFO full and busy=1 holding DONE. Pop once → 5th result enters; occupancy stays 4.
- START while busy, then RESULT read on empty → ERR=1, `irq[1]`=1 (IRQ_EN). Write CTRL 0x8 → ERR=0.
- gcd(0,7)=7, gcd(7,0)=7, gcd(0,0)=0, and with WIDTH=16 gcd(0xFFFF,0x0001)=1.
- Hold `stb` for 4 cycles on a write → exactly one ack pulse, at cycle 1. Write OPA with sel=4'b0001 → only byte 0 updates.
